spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI mode-0 target (peripheral) that answers our SPI controller on the same four-wire link.
- Oversamples sclk, cs_n and mosi in the system clock domain, decodes a one-byte command, then streams bytes into or out of a byte-wide local memory port.
- Used as the bench-side peer for the controller and as the card-side model for SD bring-up.

Parameters:
- MEMORY_SIZE_IN_BYTES, 10: local memory depth in bytes; addresses wrap at this value.
- ADDR_W, $clog2(MEMORY_SIZE_IN_BYTES): address width; must be ≤ 7.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- sclk  in  1  SPI clock from the controller; asynchronous to clk.
- cs_n  in  1  chip select, active-low; asynchronous.
- mosi  in  1  serial data from the controller, MSB first.
- miso  out  1  serial data to the controller, MSB first.
- address  out  ADDR_W  local memory address.
- data_in  in  8  read data from memory; combinational from address.
- data_out  out  8  write data to memory.
- wr  out  1  one-cycle write strobe.
- active  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse at end of transaction.
- byte_count  out  16  data bytes completed in current/last transaction; saturates at 0xFFFF.

Behaviour:
- Synchronisation:
  - sclk, cs_n, mosi each pass a 2-FF synchroniser.
  - Edges are detected from the registered previous sample, so a pin edge is acted on 3 clk later.
  - sclk half-period must be ≥ 4 clk.
- Mode 0:
  - mosi is sampled on detected sclk rising edges.
  - miso changes on detected falling edges.
- Reset values: miso=1, address=0, data_out=0, wr=0, active=0, done=0, byte_count=0, FSM=IDLE, bit counter=0.
- FSM states: IDLE, CMD, WRITE, READ.
  - IDLE → CMD on cs_n falling. Clears byte_count and bit counter; active=1.
  - CMD:
    - Shifts 8 bits. On the 8th rising edge, cmd[7]=1 selects WRITE and cmd[7]=0 selects READ.
    - Start address = cmd[ADDR_W-1:0]. If that value is ≥ MEMORY_SIZE_IN_BYTES, address=0.
    - cmd[6:ADDR_W] are ignored.
  - WRITE:
    - On each 8th rising edge: data_out ← assembled byte, wr=1 for exactly 1 clk at the current address.
    - The next cycle: address increments (wrap MEMORY_SIZE_IN_BYTES-1 → 0) and byte_count increments.
  - READ:
    - On a falling edge with bit counter 0, the shift register loads data_in and miso=data_in[7].
    - Later falling edges shift left.
    - On each 8th rising edge, address increments (same wrap rule) and byte_count increments.
    - The first data byte comes from the start address, loaded on the 8th falling edge of the command byte.
  - Any state → IDLE on cs_n rising.
    - A partial byte is discarded; no wr is issued.
    - done=1 for 1 clk (also from CMD); active=0.
    - address and byte_count hold until the next cs_n falling edge.
- miso in IDLE, CMD and WRITE is 1 (idle high), subject to the optional feature.
- cs_n and sclk edges detected in the same cycle: cs_n takes priority, and the sclk edge is ignored.
- rst asserted mid-transaction: all outputs return to reset values immediately, no wr is generated, and the FSM stays in IDLE until a fresh cs_n falling edge after rst deasserts. A transaction already in progress at release (cs_n low) is ignored.

Optional Feature:
- Macro: SPI_TARGET_MISO_HIZ_EN.
- Defined: miso is 1'bz whenever synchronised cs_n is high or the FSM is IDLE, so multiple targets can share the line.
- Undefined: miso is driven 1 in those conditions.
- READ and CMD/WRITE behaviour is unchanged either way.

Test Plan:
- Memory preloaded 'hAA,1..9. cs_n low; send 0x83, 0x11, 0x22; cs_n high → two wr pulses: mem[3]=0x11, mem[4]=0x22. byte_count=2, one done pulse, address=5.
- Send 0x08, then clock 3 bytes with mosi=0 → miso returns 0x08, 0x09, 0xAA (wrap to address 0); byte_count=3.
- Send 0x0C (out of range) then read 1 byte → miso returns 0xAA (start address clamped to 0).
- Send 0x81, then deassert cs_n after 5 bits of the data byte → no wr pulse, mem[1] unchanged, done pulses once, byte_count=0.
- Assert rst during bit 4 of the second READ byte → miso=1 (or z with macro), active=0 within one clk. A new 0x02 read transaction then returns 0x02.
- Build with SPI_TARGET_MISO_HIZ_EN → miso=z with cs_n high, 1st read byte still correct. Build without → miso=1 with cs_n high.

Source files
------------

// File: rtl/spi_target_if.sv
// Four-wire SPI link between a controller (master) and a target (slave).
// miso is 4-state so a target may release it when the line is shared.
interface spi_target_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the link in the clk domain, decodes a command byte, then
// streams bytes to/from a byte-wide memory port. Define SPI_TARGET_MISO_HIZ_EN to release miso when idle.
module spi_target #(
  parameter int MEMORY_SIZE_IN_BYTES = 10,
  parameter int ADDR_W               = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  spi_target_if.slave       spi,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              wr,
  output logic              active,
  output logic              done,
  output logic [15:0]       byte_count
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE_IN_BYTES - 1);

  state_t      state;
  logic [2:0]  sclk_sr;   // [0] meta, [1] synchronised, [2] previous sample
  logic [2:0]  cs_sr;
  logic [1:0]  mosi_sr;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [6:0]  shift_out;
  logic        miso_q;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0]  rx_byte;
  logic [ADDR_W-1:0] start_addr;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign sclk_rise  = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall  = ~sclk_sr[1] & sclk_sr[2];
  assign cs_fall    = ~cs_sr[1] & cs_sr[2];
  assign cs_rise    = cs_sr[1] & ~cs_sr[2];
  assign rx_byte    = {shift_in, mosi_sr[1]};
  assign start_addr = (32'(rx_byte[ADDR_W-1:0]) < 32'(MEMORY_SIZE_IN_BYTES))
                      ? rx_byte[ADDR_W-1:0] : '0;

  // cs_n resets to "low" so a transaction already running when rst releases
  // never shows a falling edge and is ignored until cs_n goes high and low again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi.sclk};
      cs_sr   <= {cs_sr[1:0], spi.cs_n};
      mosi_sr <= {mosi_sr[0], spi.mosi};
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the values from the start of the cycle, whatever the order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      miso_q     <= 1'b1;
      address    <= '0;
      data_out   <= '0;
      wr         <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;

      // A write strobe retires its byte on the following cycle.
      if (wr) begin
        address    <= next_addr(address);
        byte_count <= sat_inc(byte_count);
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state      <= CMD;
            bit_cnt    <= '0;
            byte_count <= '0;
            active     <= 1'b1;
            miso_q     <= 1'b1;
          end
        end

        default: begin
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            active  <= 1'b0;
            done    <= 1'b1;
            miso_q  <= 1'b1;
          end else if (sclk_rise) begin
            shift_in <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case (state)
                CMD: begin
                  state   <= rx_byte[7] ? WRITE : READ;
                  address <= start_addr;
                end
                WRITE: begin
                  data_out <= rx_byte;
                  wr       <= 1'b1;
                end
                READ: begin
                  address    <= next_addr(address);
                  byte_count <= sat_inc(byte_count);
                end
                default: ;
              endcase
            end
          end else if (sclk_fall && state == READ) begin
            // Byte boundary: the command's last falling edge fetches the first byte.
            if (bit_cnt == 3'd0) begin
              shift_out <= data_in[6:0];
              miso_q    <= data_in[7];
            end else begin
              shift_out <= {shift_out[5:0], 1'b0};
              miso_q    <= shift_out[6];
            end
          end
        end
      endcase
    end
  end

`ifdef SPI_TARGET_MISO_HIZ_EN
  assign spi.miso = (cs_sr[1] || state == IDLE) ? 1'bz : miso_q;
`else
  assign spi.miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives the SPI link as a mode-0 controller and
// models the local memory; expected values are hand-computed constants.
module tb_spi_target;

  localparam int HALF = 80;   // sclk half-period in ns (8 clk)

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        wr, active, done;
  logic [15:0] byte_count;

  logic [7:0]  mem [10];
  logic        preload;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        miso_idle;

  spi_target_if spi_bus();

  spi_target #(.MEMORY_SIZE_IN_BYTES(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi_bus),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .wr         (wr),
    .active     (active),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  assign data_in = (address < 4'd10) ? mem[address] : 8'h00;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 10; i++) mem[i] <= (i == 0) ? 8'hAA : 8'(i);
    end else if (wr) begin
      mem[address] <= data_out;
    end
  end

  always @(posedge clk) begin
    if (wr)   wr_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shifts the top n bits of tx out on mosi; rx collects miso at each rising edge.
  task automatic send_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_bus.mosi = tx[i];
      #HALF;
      spi_bus.sclk = 1'b1;
      rx[i] = spi_bus.miso;
      #HALF;
      spi_bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_bus.cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    spi_bus.cs_n = 1'b1;
    #HALF;
  endtask

  initial begin
    logic [7:0] rx;
    int wr_base, done_base;

`ifdef SPI_TARGET_MISO_HIZ_EN
    miso_idle = 1'bz;
`else
    miso_idle = 1'b1;
`endif

    rst          = 1'b1;
    preload      = 1'b1;
    spi_bus.cs_n = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.mosi = 1'b0;
    #23;
    check("rst_miso",       16'(spi_bus.miso), 16'(miso_idle));
    check("rst_address",    16'(address),      16'h0);
    check("rst_data_out",   16'(data_out),     16'h0);
    check("rst_wr",         16'(wr),           16'h0);
    check("rst_active",     16'(active),       16'h0);
    check("rst_done",       16'(done),         16'h0);
    check("rst_byte_count", byte_count,        16'h0);
    rst     = 1'b0;
    preload = 1'b0;
    #40;

    // Write 0x11, 0x22 starting at address 3.
    wr_base = wr_cnt; done_base = done_cnt;
    cs_low();
    send_bits(8'h83, 8, rx);
    check("wr_cmd_miso", 16'(rx), 16'hFF);
    check("wr_active",   16'(active), 16'h1);
    send_bits(8'h11, 8, rx);
    check("wr_data_miso", 16'(rx), 16'hFF);
    send_bits(8'h22, 8, rx);
    cs_high();
    check("wr_pulses",     16'(wr_cnt - wr_base),     16'd2);
    check("wr_mem3",       16'(mem[3]),               16'h11);
    check("wr_mem4",       16'(mem[4]),               16'h22);
    check("wr_byte_count", byte_count,                16'd2);
    check("wr_done",       16'(done_cnt - done_base), 16'd1);
    check("wr_address",    16'(address),              16'd5);
    check("wr_active_end", 16'(active),               16'h0);

    // Read three bytes from address 8, wrapping to 0.
    cs_low();
    send_bits(8'h08, 8, rx);
    check("rd_cmd_miso", 16'(rx), 16'hFF);
    send_bits(8'h00, 8, rx);
    check("rd_byte0", 16'(rx), 16'h08);
    send_bits(8'h00, 8, rx);
    check("rd_byte1", 16'(rx), 16'h09);
    send_bits(8'h00, 8, rx);
    check("rd_byte2_wrap", 16'(rx), 16'hAA);
    cs_high();
    check("rd_byte_count", byte_count,    16'd3);
    check("rd_address",    16'(address),  16'd1);

    // Out-of-range start address clamps to 0.
    cs_low();
    send_bits(8'h0C, 8, rx);
    send_bits(8'h00, 8, rx);
    check("clamp_byte", 16'(rx), 16'hAA);
    cs_high();
    check("clamp_byte_count", byte_count, 16'd1);

    // Aborted write: 5 bits of a data byte, then cs_n high.
    wr_base = wr_cnt; done_base = done_cnt;
    cs_low();
    send_bits(8'h81, 8, rx);
    send_bits(8'h55, 5, rx);
    cs_high();
    check("abort_wr",         16'(wr_cnt - wr_base),     16'd0);
    check("abort_mem1",       16'(mem[1]),               16'h01);
    check("abort_done",       16'(done_cnt - done_base), 16'd1);
    check("abort_byte_count", byte_count,                16'd0);
    check("abort_address",    16'(address),              16'd1);

    // Reset during bit 4 of the second read byte.
    cs_low();
    send_bits(8'h05, 8, rx);
    send_bits(8'h00, 8, rx);
    check("rst_rd_byte0", 16'(rx), 16'h05);
    send_bits(8'h00, 4, rx);
    rst = 1'b1;
    #10;
    check("midrst_miso",       16'(spi_bus.miso), 16'(miso_idle));
    check("midrst_active",     16'(active),       16'h0);
    check("midrst_address",    16'(address),      16'h0);
    check("midrst_byte_count", byte_count,        16'h0);
    #20;
    rst = 1'b0;
    done_base = done_cnt;
    send_bits(8'hFF, 4, rx);
    check("postrst_ignored", 16'(active), 16'h0);
    cs_high();
    check("postrst_no_done", 16'(done_cnt - done_base), 16'd0);

    // Fresh read of address 2 after reset.
    cs_low();
    send_bits(8'h02, 8, rx);
    check("fresh_active", 16'(active), 16'h1);
    send_bits(8'h00, 8, rx);
    check("fresh_byte", 16'(rx), 16'h02);
    cs_high();
    check("fresh_byte_count", byte_count, 16'd1);
    check("idle_miso", 16'(spi_bus.miso), 16'(miso_idle));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
